// File: rtl/timebase_pkg.sv
// Shared encodings for the timebase tick generator: FSM states and counting modes.
// Imported by the counter top level.
package timebase_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timebase_tc_shadow.sv
// Terminal-count update port: accepts tc_in, holds it in a shadow while a period is in flight,
// and strobes tc_load toward the counter when the new value may take effect.
module timebase_tc_shadow #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] tc_in,
  input  logic             tc_valid,
  output logic             tc_ready,
  input  logic             direct_ok,
  input  logic             apply,
  output logic             tc_load,
  output logic [WIDTH-1:0] tc_load_val
);

  logic             pending;
  logic [WIDTH-1:0] shadow;
  logic             accept;

  assign tc_ready = ~pending;
  assign accept   = tc_valid & tc_ready;

  // While pending, tc_ready is low, so a fresh accept cannot collide with a shadow apply.
  assign tc_load     = (accept & direct_ok) | (pending & apply);
  assign tc_load_val = pending ? shadow : tc_in;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending <= 1'b0;
      shadow  <= '0;
    end else if (pending) begin
      if (apply) pending <= 1'b0;
    end else if (accept && !direct_ok) begin
      shadow  <= tc_in;
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/timebase_tick_gen.sv
// Programmable prescaler: one-cycle tick every (tc_active+1) enabled clocks, periodic or one-shot.
// Optional tick counter on tick_cnt when TIMEBASE_TICK_CNT_EN is defined.
module timebase_tick_gen
  import timebase_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DEFAULT_TC = 999,
  parameter int AUTOSTART  = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc_in,
  input  logic             tc_valid,
  output logic             tc_ready,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam logic [WIDTH-1:0] TC_RST    = DEFAULT_TC[WIDTH-1:0];
  localparam logic [1:0]       ST_RESET  = (AUTOSTART != 0) ? ST_RUN : ST_IDLE;

  logic [1:0]       state;
  logic [WIDTH-1:0] tc_active;
  logic             tc_hit;
  logic             tc_load;
  logic [WIDTH-1:0] tc_load_val;

  assign tc_hit = (state == ST_RUN) & enable & (count == tc_active);
  assign tick   = tc_hit & ~start;
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  timebase_tc_shadow #(.WIDTH(WIDTH)) u_tc_shadow (
    .clk         (clk),
    .resetn      (resetn),
    .tc_in       (tc_in),
    .tc_valid    (tc_valid),
    .tc_ready    (tc_ready),
    .direct_ok   ((state != ST_RUN) | tc_hit),
    .apply       (tc_hit | start | stop),
    .tc_load     (tc_load),
    .tc_load_val (tc_load_val)
  );

  // Every load point also zeroes count, so count <= tc_active holds across shrinking updates.
  always_ff @(posedge clk) begin
    if (!resetn) tc_active <= TC_RST;
    else if (tc_load) tc_active <= tc_load_val;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_RESET;
      count <= '0;
    end else if (stop) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (start) begin
      state <= ST_RUN;
      count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (tc_hit) begin
            count <= '0;
            if (mode == MODE_ONESHOT) state <= ST_DONE;
          end else if (enable) begin
            count <= count + WIDTH'(1);
          end
        end
        ST_IDLE, ST_DONE: count <= '0;
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

`ifdef TIMEBASE_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn || start) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= tick_cnt_q + CNT_W'(1);
  end

  assign tick_cnt = tick_cnt_q;
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_timebase_tick_gen.sv
// Randomized and directed bench for timebase_tick_gen against a cycle-level behavioural model.
// Default parameters: WIDTH=10, DEFAULT_TC=999, AUTOSTART=1.
module tb_timebase_tick_gen;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

`ifdef TIMEBASE_TICK_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, enable, start, stop, mode, tc_valid;
  logic [9:0]  tc_in;
  logic        tc_ready, tick, busy, done;
  logic [9:0]  count;
  logic [15:0] tick_cnt;

  always #5 clk = ~clk;

  timebase_tick_gen #(.WIDTH(10), .DEFAULT_TC(999), .AUTOSTART(1), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .tc_in(tc_in), .tc_valid(tc_valid), .tc_ready(tc_ready),
    .tick(tick), .count(count), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  mstate_t m_state;
  int m_cnt, m_tc, m_shadow, m_tcnt;
  bit m_pend, m_acc;

  int cyc;
  int tick_at[$];
  logic last_tick, last_rdy, last_busy, last_done;
  int last_cnt, last_tcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = M_RUN; m_cnt = 0; m_tc = 999; m_shadow = 0;
    m_pend = 0; m_acc = 0; m_tcnt = 0;
  endtask

  task automatic model_step(input logic rn, en, st, sp, md, tv, input logic [9:0] ti);
    bit hit;
    if (!rn) begin
      model_reset();
      return;
    end
    hit   = (m_state == M_RUN) && en && (m_cnt == m_tc);
    m_acc = tv && !m_pend;
    if (st) m_tcnt = 0;
    else if (hit) m_tcnt = (m_tcnt + 1) % 65536;
    if (m_pend) begin
      if (hit || st || sp) begin m_tc = m_shadow; m_pend = 0; end
    end else if (m_acc) begin
      if (m_state != M_RUN || hit) m_tc = int'(ti);
      else begin m_shadow = int'(ti); m_pend = 1; end
    end
    if (sp) begin m_state = M_IDLE; m_cnt = 0; end
    else if (st) begin m_state = M_RUN; m_cnt = 0; end
    else if (hit) begin m_cnt = 0; if (md) m_state = M_DONE; end
    else if (m_state == M_RUN && en) m_cnt++;
  endtask

  // One clock: drive on the falling edge, check just after, advance the model at the rising edge.
  task automatic step(input logic rn, en, st, sp, md, tv, input logic [9:0] ti);
    logic exp_tick;
    @(negedge clk);
    resetn = rn; enable = en; start = st; stop = sp; mode = md; tc_valid = tv; tc_in = ti;
    #1;
    exp_tick = (m_state == M_RUN) && en && (m_cnt == m_tc) && !st;
    check("tick", tick, exp_tick);
    check("count", count, m_cnt);
    check("busy", busy, m_state == M_RUN);
    check("done", done, m_state == M_DONE);
    check("tc_ready", tc_ready, !m_pend);
    check("tick_cnt", tick_cnt, CNT_ON ? m_tcnt : 0);
    check("count_le_tc", count <= m_tc, 1);
    last_tick = tick; last_rdy = tc_ready; last_busy = busy; last_done = done;
    last_cnt = count; last_tcnt = tick_cnt;
    if (tick === 1'b1) tick_at.push_back(cyc);
    @(posedge clk);
    model_step(rn, en, st, sp, md, tv, ti);
    cyc++;
  endtask

  task automatic idle_steps(input int n, input logic md);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, md, 0, 0);
  endtask

  task automatic run_to(input int c, input int tcv);
    int n = 0;
    while (!(m_tc == tcv && m_cnt == c) && n < 4000) begin
      step(1, 1, 0, 0, 0, 0, 0);
      n++;
    end
    if (n >= 4000) check("run_to_timeout", n, 0);
  endtask

  task automatic set_tc_idle(input logic [9:0] v, input logic md);
    step(1, 1, 0, 1, md, 0, 0);
    step(1, 1, 0, 0, md, 1, v);
    step(1, 1, 1, 0, md, 0, 0);
  endtask

  task automatic check_gap(input string tag, input int i, input int exp);
    check(tag, (tick_at.size() > i + 1) ? tick_at[i+1] - tick_at[i] : -1, exp);
  endtask

  initial begin
    int en_cnt, n, s, maxc;
    bit seen;
    logic e, st, sp, md, tv;

    resetn = 0; enable = 1; start = 0; stop = 0; mode = 0; tc_valid = 0; tc_in = '0;
    cyc = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset defaults and free-running period of 1000.
    tick_at.delete(); cyc = 0;
    idle_steps(2100, 0);
    check("t1_first_tick", tick_at.size() > 0 ? tick_at[0] : -1, 999);
    check_gap("t1_period", 0, 1000);

    // Enable gating with tc=9.
    set_tc_idle(9, 0);
    en_cnt = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      e = 1'($urandom_range(0, 1));
      step(1, e, 0, 0, 0, 0, 0);
      if (e) en_cnt++;
      if (last_tick) begin
        if (seen) check("t2_enabled_period", en_cnt, 10);
        seen = 1; en_cnt = 0;
      end
    end

    // Runtime update mid-period, then a second write that must wait for tc_ready.
    set_tc_idle(999, 0);
    run_to(500, 999);
    step(1, 1, 0, 0, 0, 1, 4);
    tick_at.delete();
    n = 0;
    step(1, 1, 0, 0, 0, 1, 7);
    check("t3_rdy_low", last_rdy, 0);
    while (!m_acc && n < 1000) begin step(1, 1, 0, 0, 0, 1, 7); n++; end
    if (n >= 1000) check("t3_accept_timeout", n, 0);
    idle_steps(20, 0);
    check_gap("t3_new_period", 0, 5);
    check_gap("t3_second_period", 1, 8);

    // Shrink from 999 to 3 at count 800: no wrap past 999.
    set_tc_idle(999, 0);
    run_to(800, 999);
    step(1, 1, 0, 0, 0, 1, 3);
    tick_at.delete(); maxc = 0;
    for (int i = 0; i < 220; i++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      if (last_cnt > maxc) maxc = last_cnt;
    end
    check("t4_max_count", maxc, 999);
    check_gap("t4_short_period", 0, 4);
    check_gap("t4_short_period2", 1, 4);

    // One-shot with tc=2.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1, 2);
    tick_at.delete(); s = cyc;
    step(1, 1, 1, 0, 1, 0, 0);
    idle_steps(8, 1);
    check("t5_one_tick", tick_at.size(), 1);
    check("t5_tick_delay", tick_at.size() > 0 ? tick_at[0] - s : -1, 3);
    check("t5_done", last_done, 1);
    check("t5_busy", last_busy, 0);
    check("t5_count", last_cnt, 0);
    tick_at.delete();
    step(1, 1, 1, 0, 1, 0, 0);
    idle_steps(8, 1);
    check("t5_restart_tick", tick_at.size(), 1);
    step(1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);
    check("t5_stop_wins_busy", last_busy, 0);
    check("t5_stop_wins_done", last_done, 0);

    // Stop mid-period, then reset with an update pending.
    set_tc_idle(999, 0);
    run_to(600, 999);
    tick_at.delete();
    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    check("t6_stop_count", last_cnt, 0);
    check("t6_stop_busy", last_busy, 0);
    check("t6_stop_no_tick", tick_at.size(), 0);
    step(1, 1, 1, 0, 0, 0, 0);
    run_to(100, 999);
    step(1, 1, 0, 0, 0, 1, 5);
    step(0, 1, 0, 0, 0, 0, 0);
    tick_at.delete(); cyc = 0;
    step(1, 1, 0, 0, 0, 0, 0);
    check("t6_rdy_after_reset", last_rdy, 1);
    idle_steps(1000, 0);
    check("t6_default_restored", tick_at.size() > 0 ? tick_at[0] : -1, 999);

    // Tick counter: five ticks at tc=0, then cleared by start.
    set_tc_idle(0, 0);
    idle_steps(5, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6_tick_cnt_5", last_tcnt, CNT_ON ? 5 : 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6_tick_cnt_clr", last_tcnt, 0);

    // Randomized soak.
    for (int i = 0; i < 5000; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 63) == 0);
      sp = ($urandom_range(0, 127) == 0);
      md = ($urandom_range(0, 7) == 0);
      tv = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 499) != 0), e, st, sp, md, tv, 10'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
